// File: rtl/mux_stream_n_pkg.sv
// Shared definitions for the N-channel stream multiplexer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mux_stream_n_pkg;

  // Grant mode encoding on the 'mode' input.
  localparam logic MODE_SEL = 1'b0;  // explicit channel select
  localparam logic MODE_RR  = 1'b1;  // round-robin over valid channels

  // Next channel index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority encoder: first requester at or after 'base', wrapping at NCH-1.
// Latency: combinational.
// Backpressure: none; the caller gates the grant with its own load condition.
//
// Ports:
//   req    in   NCH   request vector
//   base   in   SELW  highest-priority index this cycle (expected < NCH)
//   gnt    out  SELW  granted index (0 when nothing requests)
//   gnt_v  out  1     any request present
module rr_arbiter_n #(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] base,
  output logic [SELW-1:0] gnt,
  output logic            gnt_v
);

  int w_idx;

  // Walk from the lowest priority to the highest so the last hit wins,
  // which is the first requester in rotating order from 'base'.
  always_comb begin
    gnt   = '0;
    gnt_v = |req;
    w_idx = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = int'(base) + k;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (req[w_idx]) gnt = SELW'(w_idx);
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel stream mux: picks one channel per clk (explicit select or round-robin) into one output register.
// Latency: 1 clk from input transfer to out_valid; sustains 1 word/clk with out_ready=1.
// Backpressure: out_valid & !out_ready stalls; every in_ready drops in the same cycle.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/in_valid     flattened channel data (ch i at [i*WIDTH +: WIDTH]) and per-channel valid
//   in_ready             per-channel ready, combinational, at most one bit set
//   mode, sel            0: use channel 'sel'; 1: round-robin
//   out_data/out_ch      registered word and the channel it came from
//   out_valid/out_ready  output handshake
module mux_stream_n
  import mux_stream_n_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load;
  logic             w_sel_ok;
  logic             w_gnt_v;
  logic             w_xfer;
  logic             w_arb_v;
  logic [SELW-1:0]  w_gnt;
  logic [SELW-1:0]  w_arb_gnt;
  logic [WIDTH-1:0] w_gnt_data;

  rr_arbiter_n #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req   (in_valid),
    .base  (r_rr_ptr),
    .gnt   (w_arb_gnt),
    .gnt_v (w_arb_v)
  );

  // The register can take a word when empty or when its word leaves this cycle.
  assign w_load = !r_out_valid || out_ready;

  always_comb begin
    w_gnt    = '0;
    w_gnt_v  = 1'b0;
    // sel may exceed NCH-1 when NCH is not a power of two; such a select grants nothing.
    w_sel_ok = (int'(sel) < NCH);
    if (mode == MODE_RR) begin
      w_gnt   = w_arb_gnt;
      w_gnt_v = w_arb_v;
    end else begin
      w_gnt   = sel;
      w_gnt_v = w_sel_ok && in_valid[sel];
    end
  end

  // gnt_v already implies in_valid[gnt], so a ready grant is a transfer.
  assign w_xfer = w_load && w_gnt_v && !rst;

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(w_gnt) == i) begin
        in_ready[i] = w_xfer;
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_ch    <= w_gnt;
      if (mode == MODE_RR) r_rr_ptr <= SELW'(wrap_inc(int'(w_gnt), NCH));
    end else if (out_ready) begin
      // Drained with nothing to replace it; data and channel hold.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_stream_n.sv
// Bench for mux_stream_n: 8-channel instance checked against a scoreboard, 5-channel instance for bad-select cases.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_mux_stream_n;

  localparam int W  = 16;
  localparam int NA = 8;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel instance
  logic [NA*W-1:0] a_in_data;
  logic [NA-1:0]   a_in_valid;
  logic [NA-1:0]   a_in_ready;
  logic            a_mode;
  logic [2:0]      a_sel;
  logic [W-1:0]    a_out_data;
  logic [2:0]      a_out_ch;
  logic            a_out_valid;
  logic            a_out_ready;

  // 5-channel instance
  logic [NB*W-1:0] b_in_data;
  logic [NB-1:0]   b_in_valid;
  logic [NB-1:0]   b_in_ready;
  logic            b_mode;
  logic [2:0]      b_sel;
  logic [W-1:0]    b_out_data;
  logic [2:0]      b_out_ch;
  logic            b_out_valid;
  logic            b_out_ready;

  mux_stream_n #(.WIDTH(W), .NCH(NA)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_stream_n #(.WIDTH(W), .NCH(NB)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference state for instance A: output-register occupancy and round-robin pointer.
  logic        m_valid = 1'b0;
  int          m_ptr   = 0;
  logic [18:0] sb_q[$];  // {ch[2:0], data[15:0]} in expected output order

  // One clock of instance A with inputs already driven: checks ready and
  // occupancy, scores any word leaving the register, predicts the next one.
  task automatic cycle_a();
    logic        ld, gv;
    int          g, idx;
    logic [7:0]  er;
    logic [18:0] e;
    #1;
    ld = !m_valid || a_out_ready;
    g  = 0;
    gv = 1'b0;
    if (a_mode) begin
      for (int k = 0; k < NA && !gv; k++) begin
        idx = (m_ptr + k) % NA;
        if (a_in_valid[idx]) begin
          g  = idx;
          gv = 1'b1;
        end
      end
    end else begin
      g  = int'(a_sel);
      gv = a_in_valid[a_sel];
    end
    er = (!rst && ld && gv) ? (8'h01 << g) : 8'h00;
    chk("in_ready", 32'(a_in_ready), 32'(er));
    chk("out_valid", 32'(a_out_valid), 32'(m_valid));
    if (!rst && m_valid && a_out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("out_data", 32'(a_out_data), 32'(e[15:0]));
        chk("out_ch", 32'(a_out_ch), 32'(e[18:16]));
      end
    end
    if (!rst && ld && gv) sb_q.push_back({3'(g), a_in_data[g*W +: W]});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb_q.delete();
    end else if (ld && gv) begin
      m_valid = 1'b1;
      if (a_mode) m_ptr = (g + 1) % NA;
    end else if (a_out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    a_in_data   = '0;
    a_in_valid  = '1;
    a_mode      = 1'b0;
    a_sel       = 3'd0;
    a_out_ready = 1'b1;
    b_in_data   = '0;
    b_in_valid  = '1;
    b_mode      = 1'b0;
    b_sel       = 3'd0;
    b_out_ready = 1'b1;
    for (int i = 0; i < NA; i++) a_in_data[i*W +: W] = W'(16'h1000 + i);
    for (int i = 0; i < NB; i++) b_in_data[i*W +: W] = W'(16'h2000 + i);

    // Reset for 2 clocks with every channel valid.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'h0);
    cycle_a();
    chk("rst_out_data", 32'(a_out_data), 32'h0);
    chk("rst_out_ch", 32'(a_out_ch), 32'h0);
    chk("rst_b_valid", 32'(b_out_valid), 32'h0);
    rst = 1'b0;

    // Explicit select of channel 5.
    a_in_valid = 8'h20;
    a_in_data[5*W +: W] = 16'hA5A5;
    a_sel = 3'd5;
    #1;
    chk("sel5_ready", 32'(a_in_ready), 32'h20);
    cycle_a();
    chk("sel5_data", 32'(a_out_data), 32'hA5A5);
    chk("sel5_ch", 32'(a_out_ch), 32'd5);

    // Round-robin, every channel valid: 0..7 then 0, back to back.
    a_in_data[5*W +: W] = 16'h1005;
    a_in_valid = 8'hFF;
    a_mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle_a();
      chk("rr_seq_ch", 32'(a_out_ch), 32'(k % NA));
      chk("rr_seq_vld", 32'(a_out_valid), 32'h1);
    end

    // Move the pointer to 3 by granting channel 2 alone, then check the wrap.
    a_in_valid = 8'h04;
    cycle_a();
    a_in_valid = 8'h84;
    cycle_a();
    chk("wrap_1", 32'(a_out_ch), 32'd7);
    cycle_a();
    chk("wrap_2", 32'(a_out_ch), 32'd2);
    cycle_a();
    chk("wrap_3", 32'(a_out_ch), 32'd7);

    // Backpressure: drain, load BEEF, hold it for 3 clocks, then release.
    a_in_valid = 8'h00;
    cycle_a();
    a_mode = 1'b0;
    a_sel  = 3'd0;
    a_in_data[0*W +: W] = 16'hBEEF;
    a_in_valid  = 8'h01;
    a_out_ready = 1'b0;
    cycle_a();
    a_in_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cycle_a();
      chk("stall_data", 32'(a_out_data), 32'hBEEF);
      chk("stall_ch", 32'(a_out_ch), 32'd0);
    end
    a_out_ready = 1'b1;
    a_sel = 3'd1;
    a_in_data[1*W +: W] = 16'h1234;
    #1;
    chk("release_ready", 32'(a_in_ready), 32'h02);
    cycle_a();
    chk("release_data", 32'(a_out_data), 32'h1234);

    // Reset while a word is held discards it.
    a_out_ready = 1'b0;
    rst = 1'b1;
    cycle_a();
    rst = 1'b0;
    chk("midrst_valid", 32'(a_out_valid), 32'h0);

    // Drain everything still expected.
    a_in_valid  = 8'h00;
    a_out_ready = 1'b1;
    cycle_a();
    cycle_a();
    chk("sb_left", 32'(sb_q.size()), 32'h0);

    // 5-channel build: out-of-range select grants nothing; round-robin then picks ch0.
    b_mode = 1'b0;
    b_sel  = 3'd6;
    #1;
    chk("b_sel6_ready", 32'(b_in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("b_sel6_valid", 32'(b_out_valid), 32'h0);
    b_mode = 1'b1;
    #1;
    chk("b_rr_ready", 32'(b_in_ready), 32'h01);
    @(posedge clk);
    #1;
    chk("b_rr_valid", 32'(b_out_valid), 32'h1);
    chk("b_rr_ch", 32'(b_out_ch), 32'd0);
    chk("b_rr_data", 32'(b_out_data), 32'h2000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
